// File: rtl/school_pkg.sv
// Shared school-day timing constants and the period scheduler state type.
package school_pkg;

   typedef enum logic [1:0] {PRE, CLASS, BREAK, POST} sched_state_t;

   localparam int unsigned TIME_W      = 11;
   localparam int unsigned FIRST_START = 540;
   localparam int unsigned CLASS_LEN   = 50;
   localparam int unsigned BREAK_LEN   = 10;
   localparam int unsigned NUM_PERIODS = 7;
   localparam int unsigned NUM_DAYS    = 5;

endpackage

// File: rtl/seg_countdown.sv
// Loadable down-counter timing the remaining minutes of a class or break segment.
module seg_countdown #(
   parameter int unsigned CNT_W = school_pkg::TIME_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/period_scheduler.sv
// Turns the minute-of-day count into school period state, pulses and a weekday counter.
module period_scheduler #(
   parameter int unsigned TIME_W      = school_pkg::TIME_W,
   parameter int unsigned FIRST_START = school_pkg::FIRST_START,
   parameter int unsigned CLASS_LEN   = school_pkg::CLASS_LEN,
   parameter int unsigned BREAK_LEN   = school_pkg::BREAK_LEN,
   parameter int unsigned NUM_PERIODS = school_pkg::NUM_PERIODS,
   parameter int unsigned NUM_DAYS    = school_pkg::NUM_DAYS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TIME_W-1:0] time_in,
   input  logic              day_end,
   output logic [3:0]        period,
   output logic              in_class,
   output logic              in_break,
   output logic              period_start,
   output logic              period_end,
   output logic [2:0]        day_of_week,
   output logic              school_day_done,
   output logic              sync_err
);
   import school_pkg::*;

   sched_state_t      state_q, state_d;
   logic [3:0]        period_q, period_d;
   logic              in_class_q, in_break_q;
   logic              start_q, start_d;
   logic              end_q, end_d;
   logic [2:0]        dow_q, dow_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [TIME_W-1:0] last_time_q;

   logic              tick;
   logic              seg_load, seg_dec, seg_zero;
   logic [TIME_W-1:0] seg_val;

   assign tick = (time_in != last_time_q);

   seg_countdown #(
      .CNT_W (TIME_W)
   ) u_seg (
      .clk      (clk),
      .rst      (rst),
      .load     (seg_load),
      .dec      (seg_dec),
      .load_val (seg_val),
      .zero     (seg_zero)
   );

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      start_d  = 1'b0;
      end_d    = 1'b0;
      dow_d    = dow_q;
      done_d   = done_q;
      err_d    = err_q;
      seg_load = 1'b0;
      seg_dec  = 1'b0;
      seg_val  = '0;

      if ((time_in < last_time_q) && !day_end) begin
         err_d = 1'b1;
      end

      // Day end wins over any tick arriving in the same cycle.
      if (day_end) begin
         state_d  = PRE;
         period_d = 4'd0;
         done_d   = 1'b0;
         seg_load = 1'b1;
         dow_d    = (dow_q == 3'(NUM_DAYS - 1)) ? 3'd0 : dow_q + 3'd1;
         if (state_q == CLASS) begin
            end_d = 1'b1;
         end
      end else if (tick) begin
         case (state_q)
            PRE: begin
               if (time_in == TIME_W'(FIRST_START)) begin
                  state_d  = CLASS;
                  period_d = 4'd1;
                  start_d  = 1'b1;
                  seg_load = 1'b1;
                  seg_val  = TIME_W'(CLASS_LEN - 1);
               end else if (time_in > TIME_W'(FIRST_START)) begin
                  err_d = 1'b1;
               end
            end
            CLASS: begin
               if (!seg_zero) begin
                  seg_dec = 1'b1;
               end else begin
                  end_d = 1'b1;
                  if (period_q == 4'(NUM_PERIODS)) begin
                     state_d  = POST;
                     done_d   = 1'b1;
                     period_d = 4'd0;
                  end else begin
                     state_d  = BREAK;
                     seg_load = 1'b1;
                     seg_val  = TIME_W'(BREAK_LEN - 1);
                  end
               end
            end
            BREAK: begin
               if (!seg_zero) begin
                  seg_dec = 1'b1;
               end else begin
                  state_d  = CLASS;
                  period_d = period_q + 4'd1;
                  start_d  = 1'b1;
                  seg_load = 1'b1;
                  seg_val  = TIME_W'(CLASS_LEN - 1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PRE;
         period_q    <= 4'd0;
         in_class_q  <= 1'b0;
         in_break_q  <= 1'b0;
         start_q     <= 1'b0;
         end_q       <= 1'b0;
         dow_q       <= 3'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         last_time_q <= '0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         in_class_q  <= (state_d == CLASS);
         in_break_q  <= (state_d == BREAK);
         start_q     <= start_d;
         end_q       <= end_d;
         dow_q       <= dow_d;
         done_q      <= done_d;
         err_q       <= err_d;
         last_time_q <= time_in;
      end
   end

   assign period          = period_q;
   assign in_class        = in_class_q;
   assign in_break        = in_break_q;
   assign period_start    = start_q;
   assign period_end      = end_q;
   assign day_of_week     = dow_q;
   assign school_day_done = done_q;
   assign sync_err        = err_q;

endmodule

// File: tb/tb_period_scheduler.sv
// Self-checking bench for period_scheduler: vector table, directed day sequences, random stream.
module tb_period_scheduler;

   localparam int FS  = 540;
   localparam int CL  = 50;
   localparam int BL  = 10;
   localparam int NP  = 7;
   localparam int ND  = 5;
   localparam int PER = CL + BL;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        day_end = 1'b0;
   logic [10:0] time_in = '0;
   logic [3:0]  period;
   logic        in_class, in_break, period_start, period_end;
   logic [2:0]  day_of_week;
   logic        school_day_done, sync_err;

   period_scheduler dut (
      .clk             (clk),
      .rst             (rst),
      .time_in         (time_in),
      .day_end         (day_end),
      .period          (period),
      .in_class        (in_class),
      .in_break        (in_break),
      .period_start    (period_start),
      .period_end      (period_end),
      .day_of_week     (day_of_week),
      .school_day_done (school_day_done),
      .sync_err        (sync_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: minutes elapsed since period 1 began, plus day phase.
   int m_phase;  // 0 before school, 1 running, 2 after last period
   int m_k;
   int m_dow;
   int m_last;
   bit m_err, m_start, m_end;

   typedef struct {
      bit r;
      bit de;
      int t;
      int period;
      bit ps;
      bit pe;
      bit cls;
      bit brk;
      bit done;
      bit err;
      int dow;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input int t, input bit de, input bit r);
      bit tick;
      if (r) begin
         m_phase = 0; m_k = 0; m_dow = 0; m_err = 0; m_last = 0; m_start = 0; m_end = 0;
         return;
      end
      m_start = 0;
      m_end   = 0;
      tick    = (t != m_last);
      if (t < m_last && !de) m_err = 1;
      if (de) begin
         if (m_phase == 1 && (m_k % PER) < CL) m_end = 1;
         m_phase = 0;
         m_k     = 0;
         m_dow   = (m_dow + 1) % ND;
      end else if (tick) begin
         if (m_phase == 0) begin
            if (t == FS) begin
               m_phase = 1; m_k = 0; m_start = 1;
            end else if (t > FS) begin
               m_err = 1;
            end
         end else if (m_phase == 1) begin
            m_k++;
            if (m_k == (NP - 1) * PER + CL) begin
               m_phase = 2; m_end = 1;
            end else if (m_k % PER == 0) begin
               m_start = 1;
            end else if (m_k % PER == CL) begin
               m_end = 1;
            end
         end
      end
      m_last = t;
   endtask

   task automatic check_model();
      bit run;
      int w;
      run = (m_phase == 1);
      w   = m_k % PER;
      chk("period", period, run ? m_k / PER + 1 : 0);
      chk("in_class", in_class, run && w < CL);
      chk("in_break", in_break, run && w >= CL);
      chk("period_start", period_start, m_start);
      chk("period_end", period_end, m_end);
      chk("day_of_week", day_of_week, m_dow);
      chk("school_day_done", school_day_done, m_phase == 2);
      chk("sync_err", sync_err, m_err);
   endtask

   task automatic cyc(input int t, input bit de, input bit r);
      time_in = 11'(t);
      day_end = de;
      rst     = r;
      @(posedge clk);
      #1;
      model_step(t, de, r);
      check_model();
   endtask

   task automatic do_reset();
      cyc(0, 0, 1);
      cyc(0, 0, 0);
   endtask

   initial begin
      int nstart, nend, first_start, last_end, t;

      vecs[0]  = '{1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0, 530, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 560, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[4]  = '{1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
      vecs[5]  = '{0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 1};
      vecs[6]  = '{0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 2};
      vecs[7]  = '{0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 3};
      vecs[8]  = '{0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 4};
      vecs[9]  = '{0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0};
      vecs[10] = '{0, 0, 539, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[11] = '{0, 0, 540, 1, 1, 0, 1, 0, 0, 0, 0};
      vecs[12] = '{0, 0, 541, 1, 0, 0, 1, 0, 0, 0, 0};
      vecs[13] = '{0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 1};
      vecs[14] = '{0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1};

      foreach (vecs[i]) begin
         cyc(vecs[i].t, vecs[i].de, vecs[i].r);
         chk($sformatf("vec%0d_period", i), period, vecs[i].period);
         chk($sformatf("vec%0d_start", i), period_start, vecs[i].ps);
         chk($sformatf("vec%0d_end", i), period_end, vecs[i].pe);
         chk($sformatf("vec%0d_class", i), in_class, vecs[i].cls);
         chk($sformatf("vec%0d_break", i), in_break, vecs[i].brk);
         chk($sformatf("vec%0d_done", i), school_day_done, vecs[i].done);
         chk($sformatf("vec%0d_err", i), sync_err, vecs[i].err);
         chk($sformatf("vec%0d_dow", i), day_of_week, vecs[i].dow);
      end

      // Full-day sweep with default timing.
      do_reset();
      nstart = 0; nend = 0; first_start = -1; last_end = -1;
      for (int m = 1; m < 1440; m++) begin
         cyc(m, 0, 0);
         if (period_start) begin
            nstart++;
            if (first_start < 0) first_start = m;
         end
         if (period_end) begin
            nend++;
            last_end = m;
         end
         if (m == 595) chk("sweep_break_595", in_break, 1);
         if (m == 900) chk("sweep_p7_900", period, 7);
         if (m == 949) chk("sweep_done_949", school_day_done, 0);
         if (m == 950) chk("sweep_done_950", school_day_done, 1);
      end
      chk("sweep_nstart", nstart, NP);
      chk("sweep_nend", nend, NP);
      chk("sweep_first_start", first_start, FS);
      chk("sweep_last_end", last_end, 950);

      // Day end cuts period 2 short.
      do_reset();
      for (int m = 1; m <= 620; m++) cyc(m, 0, 0);
      chk("de620_period_before", period, 2);
      cyc(620, 1, 0);
      chk("de620_end", period_end, 1);
      chk("de620_period", period, 0);
      chk("de620_class", in_class, 0);
      chk("de620_dow", day_of_week, 1);

      // Frozen time holds the segment counter.
      do_reset();
      for (int m = 1; m <= 545; m++) cyc(m, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(545, 0, 0);
         chk("hold_period", period, 1);
         chk("hold_pulse", period_start | period_end, 0);
      end
      for (int m = 546; m <= 590; m++) cyc(m, 0, 0);
      chk("hold_end_590", period_end, 1);

      // Backwards jump mid-day, then rst clears the sticky flag.
      do_reset();
      for (int m = 1; m <= 700; m++) cyc(m, 0, 0);
      cyc(300, 0, 0);
      chk("drop_err", sync_err, 1);
      cyc(300, 0, 1);
      chk("drop_err_rst", sync_err, 0);

      // rst together with day_end overrides everything.
      do_reset();
      cyc(0, 1, 0);
      chk("pre_rst_dow", day_of_week, 1);
      for (int m = 1; m <= 905; m++) cyc(m, 0, 0);
      cyc(905, 1, 1);
      chk("rst_de_period", period, 0);
      chk("rst_de_end", period_end, 0);
      chk("rst_de_class", in_class, 0);
      chk("rst_de_dow", day_of_week, 0);

      // Random stream: mostly advancing minutes with holds, jumps, day ends and resets.
      do_reset();
      t = 0;
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 1) begin
            t = 0;
            cyc(t, 0, 1);
         end else if (r < 3 || t >= 1439) begin
            t = 0;
            cyc(t, 1, 0);
         end else if (r < 10) begin
            cyc(t, 0, 0);
         end else if (r < 11) begin
            t = int'($urandom_range(0, 1439));
            cyc(t, 0, 0);
         end else begin
            t++;
            cyc(t, 0, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
